// File: rtl/mesh_flit_ejector.sv
// mesh_flit_ejector: tile endpoint for the 34-bit mesh flit stream.
// Flits addressed to TILE_ID are queued in a local FIFO and presented on a
// valid/ready interface; other valid flits pass through after one register.
// The mesh has no backpressure, so overflow is dropped per packet.
// Optional statistics counters are built when MESH_EJECTOR_STATS_EN is defined;
// otherwise pkt_count and drop_count read as zero.
module mesh_flit_ejector #(
  parameter logic [3:0]  TILE_ID = 4'h0,
  parameter int unsigned DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [33:0] flit_in,
  output logic [33:0] flit_out,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_last,
  output logic [3:0]  rx_src,
  output logic [7:0]  rx_addr,
  output logic [15:0] rx_data,
  input  logic        err_clr,
  output logic        err_ovf,
  output logic        err_proto,
  output logic [7:0]  pkt_count,
  output logic [7:0]  drop_count
);

  localparam int unsigned AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } state_t;

  state_t state, state_n;

  logic        f_valid, f_last;
  logic [3:0]  f_dest, f_src;
  logic        match;

  assign f_valid = flit_in[33];
  assign f_last  = flit_in[32];
  assign f_dest  = flit_in[31:28];
  assign f_src   = flit_in[27:24];
  assign match   = f_valid && (f_dest == TILE_ID);

  logic [28:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty;
  logic        push, pop;
  logic        drop, inc_pkt, set_ovf, set_proto, latch_src;
  logic [3:0]  cur_src;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rx_valid && rx_ready;

  // Head outputs come straight from storage; masked to zero while empty.
  always_comb begin
    rx_valid = !empty;
    {rx_last, rx_src, rx_addr, rx_data} = empty ? 29'd0 : mem[rd_ptr[AW-1:0]];
  end

  // Packet-level accept/drop decisions, evaluated only on matching flits.
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    drop      = 1'b0;
    inc_pkt   = 1'b0;
    set_ovf   = 1'b0;
    set_proto = 1'b0;
    latch_src = 1'b0;
    if (match) begin
      unique case (state)
        IDLE: begin
          latch_src = !f_last;
          if (!full) begin
            push = 1'b1;
            if (f_last) inc_pkt = 1'b1;
            else        state_n = IN_PKT;
          end else begin
            drop    = 1'b1;
            set_ovf = 1'b1;
            if (!f_last) state_n = DROP;
          end
        end
        IN_PKT: begin
          if (f_src == cur_src) begin
            if (!full) begin
              push = 1'b1;
              if (f_last) begin
                inc_pkt = 1'b1;
                state_n = IDLE;
              end
            end else begin
              drop    = 1'b1;
              set_ovf = 1'b1;
              state_n = f_last ? IDLE : DROP;
            end
          end else begin
            drop      = 1'b1;
            set_proto = 1'b1;
          end
        end
        DROP: begin
          drop = 1'b1;
          if (f_src != cur_src) set_proto = 1'b1;
          else if (f_last)      state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, latched source and FIFO pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cur_src <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state <= state_n;
      if (latch_src) cur_src <= f_src;
      if (push)      wr_ptr  <= wr_ptr + 1'b1;
      if (pop)       rd_ptr  <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {f_last, f_src, flit_in[23:16], flit_in[15:0]};
  end

  // Pass-through register, cleared on any cycle without foreign traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flit_out <= '0;
    else     flit_out <= (f_valid && !match) ? flit_in : '0;
  end

  // Sticky error flags; err_clr wins over same-cycle sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else if (err_clr) begin
      err_ovf   <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (set_ovf)   err_ovf   <= 1'b1;
      if (set_proto) err_proto <= 1'b1;
    end
  end

`ifdef MESH_EJECTOR_STATS_EN
  logic [7:0] pkt_q, drop_q;

  // Saturating packet and drop counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else if (err_clr) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (inc_pkt && pkt_q != 8'hFF) pkt_q  <= pkt_q + 1'b1;
      if (drop && drop_q != 8'hFF)   drop_q <= drop_q + 1'b1;
    end
  end

  assign pkt_count  = pkt_q;
  assign drop_count = drop_q;
`else
  logic stats_unused;
  assign stats_unused = ^{inc_pkt, drop};
  assign pkt_count    = 8'h00;
  assign drop_count   = 8'h00;
`endif

endmodule
